pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer: issues the PC to memory, waits for read data with a
// bounded timeout, loads the instruction register and advances the PC.
module pc_fetch_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic        ext_ld_pc,
  input  logic [1:0]  ext_pc_sel,
  input  logic [15:0] pc_next,
  input  logic        mem_rdy,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pc,
  output logic [1:0]  pc_sel,
  output logic [15:0] mar,
  output logic        mem_rd,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        fetch_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mdr_q, mdr_d;
  logic [3:0]  wcnt_q, wcnt_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= 16'h0000;
      mar_q   <= 16'h0000;
      ir_q    <= 16'h0000;
      mdr_q   <= 16'h0000;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        // A fetch request wins over a simultaneous external PC load.
        if (fetch_req)      state_d = S_ADDR;
        else if (ext_ld_pc) pc_d    = pc_next;
      end
      S_ADDR: begin
        mar_d   = pc_q;
        pc_d    = pc_next;
        wcnt_d  = 4'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rdy) begin
          mdr_d   = mem_rdata;
          state_d = S_LOAD;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) state_d = S_ERR;
        end
      end
      S_LOAD: begin
        ir_d    = mdr_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The PC-mux is forced to the increment path only while the address is issued.
  assign pc_sel    = (state_q == S_ADDR) ? 2'b00 : ext_pc_sel;
  assign pc        = pc_q;
  assign mar       = mar_q;
  assign ir        = ir_q;
  assign mem_rd    = (state_q == S_WAIT);
  assign ir_valid  = (state_q == S_DONE);
  assign fetch_err = (state_q == S_ERR);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a transaction-level model expands each
// fetch into its expected per-cycle outputs, checked every cycle, plus literal pins.
module tb_pc_fetch_unit;

  logic        Clk, Reset;
  logic        fetch_req, ext_ld_pc;
  logic [1:0]  ext_pc_sel;
  logic [15:0] pc_next;
  logic        mem_rdy;
  logic [15:0] mem_rdata;
  logic [15:0] pc, mar, ir;
  logic [1:0]  pc_sel;
  logic        mem_rd, ir_valid, fetch_err, busy;

  pc_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .fetch_req(fetch_req), .ext_ld_pc(ext_ld_pc),
    .ext_pc_sel(ext_pc_sel), .pc_next(pc_next), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .pc(pc), .pc_sel(pc_sel), .mar(mar), .mem_rd(mem_rd),
    .ir(ir), .ir_valid(ir_valid), .fetch_err(fetch_err), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Environment: PC-mux and a memory that answers after rdy_delay WAIT cycles.
  logic [15:0] adder_val, bus_val, rd_data;
  int          rdy_delay;
  logic [4:0]  wcnt_tb;

  always_comb begin
    case (pc_sel)
      2'b00:   pc_next = pc + 16'd1;
      2'b01:   pc_next = adder_val;
      default: pc_next = bus_val;
    endcase
  end

  always @(posedge Clk or negedge Reset)
    if (!Reset) wcnt_tb <= 5'd0;
    else        wcnt_tb <= mem_rd ? wcnt_tb + 5'd1 : 5'd0;

  assign mem_rdy   = mem_rd && (int'(wcnt_tb) == rdy_delay);
  assign mem_rdata = mem_rdy ? rd_data : 16'hBAD0;

  // Model: queue of expected per-cycle outputs; idle values when empty.
  typedef struct packed {
    logic busy, mem_rd, ir_valid, fetch_err, addr;
    logic [15:0] pc, mar, ir;
  } rec_t;

  rec_t        q[$];
  rec_t        cmp_e;
  logic [15:0] m_pc, m_mar, m_ir;
  bit          cmp_en = 0;

  function automatic rec_t mk(input logic b, rd, v, er, ad, input logic [15:0] p, m, i);
    rec_t r;
    r.busy = b; r.mem_rd = rd; r.ir_valid = v; r.fetch_err = er; r.addr = ad;
    r.pc = p; r.mar = m; r.ir = i;
    return r;
  endfunction

  always @(negedge Clk) begin
    if (cmp_en && Reset) begin
      if (q.size() > 0) cmp_e = q.pop_front();
      else              cmp_e = mk(0, 0, 0, 0, 0, m_pc, m_mar, m_ir);
      chk("ctl{busy,mem_rd,ir_valid,fetch_err}", {busy, mem_rd, ir_valid, fetch_err},
          {cmp_e.busy, cmp_e.mem_rd, cmp_e.ir_valid, cmp_e.fetch_err});
      chk("pc", pc, cmp_e.pc);
      chk("mar", mar, cmp_e.mar);
      chk("ir", ir, cmp_e.ir);
      chk("pc_sel", pc_sel, cmp_e.addr ? 2'b00 : ext_pc_sel);
    end
  end

  // Monitors for literal pins.
  int ecount = 0, n_rd = 0, n_val = 0, n_err = 0, e_valid = -1, e0 = 0;
  always @(posedge Clk) ecount++;
  always @(negedge Clk) begin
    if (mem_rd) n_rd++;
    if (fetch_err) n_err++;
    if (ir_valid) begin
      n_val++;
      if (e_valid < 0) e_valid = ecount;
    end
  end

  task automatic clr_mon();
    n_rd = 0; n_val = 0; n_err = 0; e_valid = -1;
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [15:0] val);
    @(posedge Clk); #1;
    q.push_back(mk(0, 0, 0, 0, 0, m_pc, m_mar, m_ir));
    ext_ld_pc = 1'b1; ext_pc_sel = sel;
    if (sel == 2'b01) adder_val = val; else bus_val = val;
    m_pc = val;
    @(posedge Clk); #1;
    ext_ld_pc = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] data, input int delay, input bit ld_too);
    int nw;
    @(posedge Clk); #1;
    e0 = ecount;
    clr_mon();
    nw = (delay < 16) ? delay + 1 : 16;
    q.push_back(mk(0, 0, 0, 0, 0, m_pc, m_mar, m_ir));
    q.push_back(mk(1, 0, 0, 0, 1, m_pc, m_mar, m_ir));
    for (int i = 0; i < nw; i++) q.push_back(mk(1, 1, 0, 0, 0, m_pc + 16'd1, m_pc, m_ir));
    if (delay < 16) begin
      q.push_back(mk(1, 0, 0, 0, 0, m_pc + 16'd1, m_pc, m_ir));
      q.push_back(mk(1, 0, 1, 0, 0, m_pc + 16'd1, m_pc, data));
      m_ir = data;
    end else begin
      q.push_back(mk(1, 0, 0, 1, 0, m_pc + 16'd1, m_pc, m_ir));
    end
    m_mar = m_pc;
    m_pc  = m_pc + 16'd1;
    fetch_req = 1'b1; rdy_delay = delay; rd_data = data;
    ext_ld_pc = ld_too; ext_pc_sel = 2'b01; adder_val = 16'h5555;
    @(posedge Clk); #1;
    fetch_req = 1'b0; ext_ld_pc = 1'b0; ext_pc_sel = 2'b10;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      if (q.size() == 0) break;
    end
    chk("fetch_completes_in_budget", q.size(), 0);
    q.delete();
    #1;
  endtask

  initial begin
    Reset = 1'b0; fetch_req = 1'b0; ext_ld_pc = 1'b0; ext_pc_sel = 2'b10;
    adder_val = 16'h0; bus_val = 16'h0; rd_data = 16'h0; rdy_delay = 0;
    m_pc = 16'h0; m_mar = 16'h0; m_ir = 16'h0;
    #2;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_mar", mar, 16'h0000);
    chk("reset_ir", ir, 16'h0000);
    chk("reset_ctl", {busy, mem_rd, ir_valid, fetch_err}, 4'b0000);
    chk("reset_pc_sel", pc_sel, 2'b10);
    @(posedge Clk); #1;
    Reset = 1'b1; cmp_en = 1;

    // Load PC from the bus, then basic fetch with zero wait states.
    do_load(2'b10, 16'h3000);
    @(negedge Clk) chk("load_pc_lit", pc, 16'h3000);
    do_fetch(16'h1234, 0, 0);
    @(negedge Clk);
    chk("basic_ir_lit", ir, 16'h1234);
    chk("basic_mar_lit", mar, 16'h3000);
    chk("basic_pc_lit", pc, 16'h3001);
    chk("basic_ir_valid_count", n_val, 1);
    chk("basic_latency_edges", e_valid - e0, 4);

    // Five wait states.
    do_fetch(16'hBEEF, 5, 0);
    @(negedge Clk);
    chk("wait_mem_rd_cycles", n_rd, 6);
    chk("wait_ir_lit", ir, 16'hBEEF);
    chk("wait_ir_valid_count", n_val, 1);

    // Timeout.
    do_fetch(16'h7777, 99, 0);
    @(negedge Clk);
    chk("tmo_mem_rd_cycles", n_rd, 16);
    chk("tmo_err_count", n_err, 1);
    chk("tmo_ir_valid_count", n_val, 0);
    chk("tmo_ir_lit", ir, 16'hBEEF);
    chk("tmo_pc_lit", pc, 16'h3003);
    chk("tmo_busy", busy, 1'b0);

    // Branch then fetch.
    do_load(2'b01, 16'h4000);
    @(negedge Clk) chk("branch_pc_lit", pc, 16'h4000);
    do_fetch(16'h1111, 2, 0);
    @(negedge Clk);
    chk("branch_mar_lit", mar, 16'h4000);
    chk("branch_next_pc_lit", pc, 16'h4001);

    // Collision with external load, and PC wrap.
    do_load(2'b10, 16'hFFFF);
    do_fetch(16'h2222, 1, 1);
    @(negedge Clk);
    chk("wrap_mar_lit", mar, 16'hFFFF);
    chk("wrap_pc_lit", pc, 16'h0000);
    chk("wrap_ir_lit", ir, 16'h2222);

    // Reset in the middle of a WAIT.
    cmp_en = 0;
    @(posedge Clk); #1;
    fetch_req = 1'b1; rdy_delay = 99;
    @(posedge Clk); #1;
    fetch_req = 1'b0;
    @(posedge Clk); @(posedge Clk); #3;
    chk("pre_reset_in_wait", mem_rd, 1'b1);
    clr_mon();
    Reset = 1'b0;
    #1;
    chk("mid_reset_pc", pc, 16'h0000);
    chk("mid_reset_mar", mar, 16'h0000);
    chk("mid_reset_ir", ir, 16'h0000);
    chk("mid_reset_ctl", {busy, mem_rd, ir_valid, fetch_err}, 4'b0000);
    chk("mid_reset_pc_sel", pc_sel, ext_pc_sel);
    repeat (2) @(negedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;
    q.delete(); m_pc = 16'h0; m_mar = 16'h0; m_ir = 16'h0;
    cmp_en = 1;
    repeat (2) @(negedge Clk);
    chk("reset_no_pulses", {n_val[7:0], n_err[7:0]}, 16'h0000);

    do_fetch(16'hABCD, 0, 0);
    @(negedge Clk);
    chk("post_reset_ir_lit", ir, 16'hABCD);
    chk("post_reset_mar_lit", mar, 16'h0000);
    chk("post_reset_pc_lit", pc, 16'h0001);

    repeat (3) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
